// File: rtl/cpu_defs.sv
// Shared register-file definitions for the write-side front end.
// Widths here are the defaults of the arbiter parameters.
package cpu_defs;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous circular FIFO buffering long-latency results ahead of the write port.
// Depth must be a power of two so the pointers wrap naturally.
module wb_result_fifo #(
    parameter int unsigned Width = 37,
    parameter int unsigned Depth = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic [Width-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline write-back and buffered long-latency results onto the single
// register-file write port; tracks outstanding long-latency destinations.
module regfile_write_arbiter
    import cpu_defs::*;
#(
    parameter int unsigned width       = REG_DATA_W,
    parameter int unsigned AddrWidth   = REG_ADDR_W,
    parameter int unsigned num         = NUM_REGS,
    parameter int unsigned FifoDepth   = 2,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_wen,
    input  logic [AddrWidth-1:0] pipe_waddr,
    input  logic [width-1:0]     pipe_wdata,
    input  logic                 lu_issue,
    input  logic [AddrWidth-1:0] lu_issue_addr,
    input  logic                 lu_valid,
    output logic                 lu_ready,
    input  logic [AddrWidth-1:0] lu_waddr,
    input  logic [width-1:0]     lu_wdata,
    output logic                 RegWrite,
    output logic [AddrWidth-1:0] Write_register,
    output logic [width-1:0]     Write_data,
    output logic [num-1:0]       busy_mask,
    output logic                 wb_stall
);

    localparam int unsigned EntryW = AddrWidth + width;
    localparam int unsigned CntW   = $clog2(FifoDepth + 1);
    localparam int unsigned StW    = $clog2(StarveLimit + 1);
    localparam logic [AddrWidth-1:0] Zero = AddrWidth'(ZERO_REG);

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic [EntryW-1:0] fifo_head;
    logic              pipe_write;

    logic                 reg_write_q, reg_write_d;
    logic [AddrWidth-1:0] wreg_q, wreg_d;
    logic [width-1:0]     wdata_q, wdata_d;
    logic                 from_fifo_q, from_fifo_d;
    logic [num-1:0]       busy_q, busy_d;
    logic [StW-1:0]       starve_q, starve_d;
    logic                 stall_q, stall_d;

    assign lu_ready   = (fifo_count != CntW'(FifoDepth));
    assign pipe_write = pipe_wen && (pipe_waddr != Zero);
    // Writes to x0 complete the handshake but are dropped.
    assign fifo_push  = lu_valid && lu_ready && (lu_waddr != Zero);
    assign fifo_pop   = !pipe_write && !fifo_empty;

    wb_result_fifo #(
        .Width (EntryW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({lu_waddr, lu_wdata}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        reg_write_d = 1'b0;
        from_fifo_d = 1'b0;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        if (pipe_write) begin
            reg_write_d = 1'b1;
            wreg_d      = pipe_waddr;
            wdata_d     = pipe_wdata;
        end else if (fifo_pop) begin
            reg_write_d = 1'b1;
            from_fifo_d = 1'b1;
            wreg_d      = fifo_head[EntryW-1:width];
            wdata_d     = fifo_head[width-1:0];
        end
    end

    // Clear follows the registered write; a same-edge issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q && from_fifo_q) busy_d[wreg_q] = 1'b0;
        if (lu_issue && (lu_issue_addr != Zero)) busy_d[lu_issue_addr] = 1'b1;
    end

    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (fifo_full && pipe_wen) begin
            if (starve_q == StW'(StarveLimit - 1)) begin
                stall_d = 1'b1;
            end else begin
                starve_d = starve_q + StW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            from_fifo_q <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= '0;
            starve_q    <= '0;
            stall_q     <= 1'b0;
        end else begin
            reg_write_q <= reg_write_d;
            from_fifo_q <= from_fifo_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
        end
    end

    assign RegWrite       = reg_write_q;
    assign Write_register = wreg_q;
    assign Write_data     = wdata_q;
    assign busy_mask      = busy_q;
    assign wb_stall       = stall_q;

    a_no_wb_during_stall: assert property (@(posedge clk) disable iff (rst)
        wb_stall |-> !pipe_wen);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: write-back priority, long-result
// latency, scoreboard set/clear, starvation guard and mid-operation reset.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wen;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_issue;
    logic [4:0]  lu_issue_addr;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [31:0] busy_mask;
    logic        wb_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_wen       (pipe_wen),
        .pipe_waddr     (pipe_waddr),
        .pipe_wdata     (pipe_wdata),
        .lu_issue       (lu_issue),
        .lu_issue_addr  (lu_issue_addr),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_waddr       (lu_waddr),
        .lu_wdata       (lu_wdata),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .busy_mask      (busy_mask),
        .wb_stall       (wb_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        pipe_wen = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        lu_issue = 1'b0; lu_issue_addr = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and idle
        for (int i = 0; i < 3; i++) begin
            chk("idle_regwrite", RegWrite, 1'b0);
            chk("idle_lu_ready", lu_ready, 1'b1);
            chk("idle_busy", busy_mask, 32'h0);
            chk("idle_stall", wb_stall, 1'b0);
            tick();
        end
        chk("reset_wreg", Write_register, 5'd0);
        chk("reset_wdata", Write_data, 32'h0);

        // Pipeline write lands one cycle later; x0 write is dropped
        pipe_wen = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF;
        tick();
        chk("pipe_we", RegWrite, 1'b1);
        chk("pipe_reg", Write_register, 5'd5);
        chk("pipe_data", Write_data, 32'hDEADBEEF);
        pipe_waddr = 5'd0; pipe_wdata = 32'h11;
        tick();
        chk("pipe_x0_we", RegWrite, 1'b0);
        pipe_wen = 1'b0;

        // Long op to r9: busy, two-cycle result latency, clear one cycle later
        lu_issue = 1'b1; lu_issue_addr = 5'd9;
        tick();
        lu_issue = 1'b0;
        chk("lu9_busy_set", busy_mask[9], 1'b1);
        tick(); tick(); tick();
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h1234;
        tick();
        lu_valid = 1'b0;
        chk("lu9_no_bypass", RegWrite, 1'b0);
        chk("lu9_ready_one", lu_ready, 1'b1);
        tick();
        chk("lu9_we", RegWrite, 1'b1);
        chk("lu9_reg", Write_register, 5'd9);
        chk("lu9_data", Write_data, 32'h1234);
        chk("lu9_busy_hold", busy_mask[9], 1'b1);
        tick();
        chk("lu9_busy_clr", busy_mask[9], 1'b0);
        chk("lu9_we_done", RegWrite, 1'b0);

        // Starvation: FIFO fills under continuous pipeline writes
        lu_issue = 1'b1; lu_issue_addr = 5'd10;
        tick();
        lu_issue_addr = 5'd11;
        tick();
        lu_issue = 1'b0;
        pipe_wen = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h300;
        lu_valid = 1'b1; lu_waddr = 5'd10; lu_wdata = 32'hA;
        tick();
        chk("st_ready_after1", lu_ready, 1'b1);
        chk("st_pipe_reg", Write_register, 5'd3);
        lu_waddr = 5'd11; lu_wdata = 32'hB; pipe_wdata = 32'h301;
        tick();
        lu_valid = 1'b0;
        chk("st_ready_full", lu_ready, 1'b0);
        chk("st_no_stall0", wb_stall, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_no_stall", wb_stall, 1'b0);
            chk("st_ready_still0", lu_ready, 1'b0);
        end
        tick();
        chk("st_stall", wb_stall, 1'b1);
        chk("st_pipe_we", RegWrite, 1'b1);
        chk("st_pipe_reg2", Write_register, 5'd3);
        pipe_wen = 1'b0;
        tick();
        chk("st_stall_once", wb_stall, 1'b0);
        chk("st_head_we", RegWrite, 1'b1);
        chk("st_head_reg", Write_register, 5'd10);
        chk("st_head_data", Write_data, 32'hA);
        chk("st_ready_back", lu_ready, 1'b1);
        tick();
        chk("st_second_reg", Write_register, 5'd11);
        chk("st_second_data", Write_data, 32'hB);
        chk("st_busy10_clr", busy_mask[10], 1'b0);
        chk("st_busy11_hold", busy_mask[11], 1'b1);
        tick();
        chk("st_drained_we", RegWrite, 1'b0);
        chk("st_busy_all_clr", busy_mask, 32'h0);

        // Same-edge set and clear of r7: set wins
        lu_issue = 1'b1; lu_issue_addr = 5'd7;
        tick();
        lu_issue = 1'b0;
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h77;
        tick();
        lu_valid = 1'b0;
        tick();
        chk("r7_we", RegWrite, 1'b1);
        chk("r7_reg", Write_register, 5'd7);
        lu_issue = 1'b1; lu_issue_addr = 5'd7;
        tick();
        lu_issue = 1'b0;
        chk("r7_set_wins", busy_mask[7], 1'b1);
        tick();
        chk("r7_still_busy", busy_mask[7], 1'b1);

        // Mid-operation reset with a full FIFO discards everything
        lu_issue = 1'b1; lu_issue_addr = 5'd12;
        tick();
        lu_issue_addr = 5'd13;
        tick();
        lu_issue = 1'b0;
        pipe_wen = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h400;
        lu_valid = 1'b1; lu_waddr = 5'd12; lu_wdata = 32'hC;
        tick();
        lu_waddr = 5'd13; lu_wdata = 32'hD;
        tick();
        lu_valid = 1'b0;
        chk("rst_pre_full", lu_ready, 1'b0);
        chk("rst_pre_busy", busy_mask, 32'h0000_3080);
        pipe_wen = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", lu_ready, 1'b1);
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_we", RegWrite, 1'b0);
        chk("rst_stall", wb_stall, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_stale_we", RegWrite, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
